// File: rtl/vga_pkg.sv
// Shared VGA raster constants and the coordinate type used by the timing
// generator, colour mapper and bar logic.
package vga_pkg;

    // Default 640x480@60 geometry, in pixels and lines
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [9:0] coord_t;

    // True when lo <= v < hi
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pixel_ce_div.sv
// Pixel clock-enable divider: one-Clk pix_ce pulse every CLK_DIV cycles.
module pixel_ce_div
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Reset,
    output logic pix_ce
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;

    // Free-running 0..CLK_DIV-1 counter; with CLK_DIV=1 it stays at 0
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_q <= '0;
        end else if (div_q == LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Reset gating keeps pix_ce low in reset even when CLK_DIV=1 holds it high
    always_comb begin
        pix_ce = Reset && (div_q == LAST);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: DrawX/DrawY counters, registered hs/vs/display_en
// decode and line/frame start pulses, advanced by a pixel clock-enable.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK,
    parameter bit          SYNC_NEG  = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pix_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       display_en,
    output logic       line_start,
    output logic       frame_start
);

    localparam coord_t H_LAST = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t HS_LO  = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_LO  = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t x_q, y_q, x_d, y_d;
    logic   x_wrap, y_wrap;
    logic   hs_q, vs_q, de_q, ls_q, fs_q;

    pixel_ce_div #(
        .CLK_DIV (CLK_DIV)
    ) u_ce_div (
        .Clk    (Clk),
        .Reset  (Reset),
        .pix_ce (pix_ce)
    );

    // Next raster position; only taken on a pixel tick
    always_comb begin
        x_wrap = (x_q == H_LAST);
        y_wrap = (y_q == V_LAST);
        x_d    = x_wrap ? '0 : x_q + 1'b1;
        y_d    = y_q;
        if (x_wrap) begin
            y_d = y_wrap ? '0 : y_q + 1'b1;
        end
    end

    // Counters plus sync/enable decoded from the next position so the
    // registered outputs line up with DrawX/DrawY without extra latency
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            x_q  <= '0;
            y_q  <= '0;
            hs_q <= SYNC_NEG;
            vs_q <= SYNC_NEG;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            if (pix_ce) begin
                x_q  <= x_d;
                y_q  <= y_d;
                hs_q <= in_window(x_d, HS_LO, HS_HI) ^ SYNC_NEG;
                vs_q <= in_window(y_d, VS_LO, VS_HI) ^ SYNC_NEG;
                de_q <= (x_d < H_VIS) && (y_d < V_VIS);
                ls_q <= x_wrap;
                fs_q <= x_wrap && y_wrap;
            end
        end
    end

    // Drive ports straight from registers
    always_comb begin
        DrawX       = x_q;
        DrawY       = y_q;
        hs          = hs_q;
        vs          = vs_q;
        display_en  = de_q;
        line_start  = ls_q;
        frame_start = fs_q;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default geometry, a shrunken
// geometry for full-frame coverage, and a CLK_DIV=1 instance.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       ce;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct packed {
        int unsigned div;
        int unsigned h_vis;
        int unsigned h_tot;
        int unsigned hs_lo;
        int unsigned hs_hi;
        int unsigned v_vis;
        int unsigned v_tot;
        int unsigned vs_lo;
        int unsigned vs_hi;
    } geom_t;

    localparam geom_t G_DEF = '{div: 2, h_vis: 640, h_tot: 800, hs_lo: 656, hs_hi: 752,
                                v_vis: 480, v_tot: 525, vs_lo: 490, vs_hi: 492};
    localparam geom_t G_S   = '{div: 2, h_vis: 8, h_tot: 15, hs_lo: 10, hs_hi: 13,
                                v_vis: 6, v_tot: 11, vs_lo: 8, vs_hi: 10};
    localparam geom_t G_1   = '{div: 1, h_vis: 640, h_tot: 800, hs_lo: 656, hs_hi: 752,
                                v_vis: 480, v_tot: 525, vs_lo: 490, vs_hi: 492};
    localparam obs_t RST_EXP = '{ce: 1'b0, x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1,
                                 de: 1'b0, ls: 1'b0, fs: 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    obs_t sb_q[$];

    logic       m_ce, m_hs, m_vs, m_de, m_ls, m_fs;
    logic [9:0] m_x, m_y;
    logic       s_ce, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic       o_ce, o_hs, o_vs, o_de, o_ls, o_fs;
    logic [9:0] o_x, o_y;
    obs_t       obs_m, obs_s, obs_o;

    assign obs_m = {m_ce, m_x, m_y, m_hs, m_vs, m_de, m_ls, m_fs};
    assign obs_s = {s_ce, s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs};
    assign obs_o = {o_ce, o_x, o_y, o_hs, o_vs, o_de, o_ls, o_fs};

    vga_timing_gen dut (
        .Clk (clk), .Reset (rst_n), .pix_ce (m_ce), .DrawX (m_x), .DrawY (m_y),
        .hs (m_hs), .vs (m_vs), .display_en (m_de), .line_start (m_ls), .frame_start (m_fs)
    );

    vga_timing_gen #(
        .CLK_DIV (2), .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (1), .SYNC_NEG (1'b1)
    ) dut_s (
        .Clk (clk), .Reset (rst_n), .pix_ce (s_ce), .DrawX (s_x), .DrawY (s_y),
        .hs (s_hs), .vs (s_vs), .display_en (s_de), .line_start (s_ls), .frame_start (s_fs)
    );

    vga_timing_gen #(
        .CLK_DIV (1)
    ) dut_1 (
        .Clk (clk), .Reset (rst_n), .pix_ce (o_ce), .DrawX (o_x), .DrawY (o_y),
        .hs (o_hs), .vs (o_vs), .display_en (o_de), .line_start (o_ls), .frame_start (o_fs)
    );

    // Expected outputs n clock edges after reset release, from raster arithmetic
    function automatic obs_t model(int unsigned n, geom_t g);
        obs_t        e;
        int unsigned p, x, y;
        logic        tick;
        p    = n / g.div;
        x    = p % g.h_tot;
        y    = (p / g.h_tot) % g.v_tot;
        tick = (n > 0) && ((n % g.div) == 0);
        e.ce = ((n % g.div) == g.div - 1);
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.hs = !((x >= g.hs_lo) && (x < g.hs_hi));
        e.vs = !((y >= g.vs_lo) && (y < g.vs_hi));
        e.de = (p != 0) && (x < g.h_vis) && (y < g.v_vis);
        e.ls = tick && (x == 0);
        e.fs = tick && (x == 0) && (y == 0);
        return e;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("ce=%0b x=%0d y=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b",
                         o.ce, o.x, o.y, o.hs, o.vs, o.de, o.ls, o.fs);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb_q.delete();
    endtask

    task automatic test_reset();
        obs_t e;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs_m !== RST_EXP) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: got %s want %s", i, fmt(obs_m), fmt(RST_EXP));
            end
        end
        checks++;
        if (obs_s !== RST_EXP) begin
            failures++;
            $display("FAIL reset_hold_small: got %s want %s", fmt(obs_s), fmt(RST_EXP));
        end
        checks++;
        if (obs_o !== RST_EXP) begin
            failures++;
            $display("FAIL reset_hold_div1: got %s want %s", fmt(obs_o), fmt(RST_EXP));
        end
        rst_n = 1'b1;
        #1;
        sb_q.delete();
        for (int n = 0; n <= 8; n++) begin
            sb_q.push_back(model(n, G_DEF));
            if (n > 0) step();
            e = sb_q.pop_front();
            checks++;
            if (obs_m !== e) begin
                failures++;
                $display("FAIL release_n%0d: got %s want %s", n, fmt(obs_m), fmt(e));
            end
            if (n == 1) begin
                checks++;
                if (m_ce !== 1'b1 || m_x !== 10'd0) begin
                    failures++;
                    $display("FAIL first_tick: got ce=%0b x=%0d want ce=1 x=0", m_ce, m_x);
                end
            end
            if (n == 2) begin
                checks++;
                if (m_x !== 10'd1) begin
                    failures++;
                    $display("FAIL first_advance: got x=%0d want 1", m_x);
                end
            end
        end
    endtask

    task automatic test_line();
        obs_t e;
        int   ls_n[$];
        int   ce_cnt, hs_low, hs_fall_x;
        logic prev_hs;
        ce_cnt = 0; hs_low = 0; hs_fall_x = -1; prev_hs = 1'b1;
        restart();
        for (int n = 0; n <= 3210; n++) begin
            sb_q.push_back(model(n, G_DEF));
            if (n > 0) step();
            e = sb_q.pop_front();
            checks++;
            if (obs_m !== e) begin
                failures++;
                $display("FAIL line_sb_n%0d: got %s want %s", n, fmt(obs_m), fmt(e));
            end
            if (m_ls === 1'b1) ls_n.push_back(n);
            if (ls_n.size() == 1) begin
                if (m_ce === 1'b1) ce_cnt++;
                if (m_hs === 1'b0) hs_low++;
            end
            if (prev_hs === 1'b1 && m_hs === 1'b0 && hs_fall_x < 0) hs_fall_x = int'(m_x);
            prev_hs = m_hs;
        end
        checks++;
        if (ls_n.size() < 2 || (ls_n[1] - ls_n[0]) != 1600) begin
            failures++;
            $display("FAIL line_period: got %0d pulses, gap %0d want gap 1600", ls_n.size(),
                     (ls_n.size() >= 2) ? ls_n[1] - ls_n[0] : -1);
        end
        checks++;
        if (ce_cnt != 800) begin
            failures++;
            $display("FAIL line_ticks: got %0d want 800", ce_cnt);
        end
        checks++;
        if (hs_low != 192) begin
            failures++;
            $display("FAIL hs_width: got %0d clk (%0d ticks) want 192 clk", hs_low, hs_low / 2);
        end
        checks++;
        if (hs_fall_x != 656) begin
            failures++;
            $display("FAIL hs_start: got x=%0d want 656", hs_fall_x);
        end
    endtask

    task automatic test_frame();
        obs_t e;
        int   fs_n[$];
        int   vmin, vmax, xmax, ymax;
        vmin = 1023; vmax = 0; xmax = 0; ymax = 0;
        restart();
        for (int n = 0; n <= 700; n++) begin
            sb_q.push_back(model(n, G_S));
            if (n > 0) step();
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                failures++;
                $display("FAIL frame_sb_n%0d: got %s want %s", n, fmt(obs_s), fmt(e));
            end
            if (s_fs === 1'b1) fs_n.push_back(n);
            if (s_vs === 1'b0) begin
                if (int'(s_y) < vmin) vmin = int'(s_y);
                if (int'(s_y) > vmax) vmax = int'(s_y);
            end
            if (int'(s_x) > xmax) xmax = int'(s_x);
            if (int'(s_y) > ymax) ymax = int'(s_y);
        end
        checks++;
        if (fs_n.size() < 2 || (fs_n[1] - fs_n[0]) != 330) begin
            failures++;
            $display("FAIL frame_period: got %0d pulses, gap %0d want gap 330", fs_n.size(),
                     (fs_n.size() >= 2) ? fs_n[1] - fs_n[0] : -1);
        end
        checks++;
        if (vmin != 8 || vmax != 9) begin
            failures++;
            $display("FAIL vs_rows: got y %0d..%0d want 8..9", vmin, vmax);
        end
        checks++;
        if (xmax != 14 || ymax != 10) begin
            failures++;
            $display("FAIL max_xy: got (%0d,%0d) want (14,10)", xmax, ymax);
        end
    endtask

    task automatic test_edges();
        logic [9:0] px, py;
        logic       hit_a, hit_b, hit_c, hit_w;
        hit_a = 1'b0; hit_b = 1'b0; hit_c = 1'b0; hit_w = 1'b0;
        restart();
        px = s_x; py = s_y;
        for (int n = 1; n <= 400; n++) begin
            step();
            if (s_x === 10'd7 && s_y === 10'd5) begin
                hit_a = 1'b1; checks++;
                if (s_de !== 1'b1) begin
                    failures++; $display("FAIL de_last_visible: got %0b want 1", s_de);
                end
            end
            if (s_x === 10'd8 && s_y === 10'd5) begin
                hit_b = 1'b1; checks++;
                if (s_de !== 1'b0) begin
                    failures++; $display("FAIL de_right_edge: got %0b want 0", s_de);
                end
            end
            if (s_x === 10'd0 && s_y === 10'd6) begin
                hit_c = 1'b1; checks++;
                if (s_de !== 1'b0) begin
                    failures++; $display("FAIL de_bottom_edge: got %0b want 0", s_de);
                end
            end
            if (px === 10'd14 && py === 10'd10 && (s_x !== px || s_y !== py)) begin
                hit_w = 1'b1; checks++;
                if (s_x !== 10'd0 || s_y !== 10'd0 || s_ls !== 1'b1 || s_fs !== 1'b1) begin
                    failures++;
                    $display("FAIL frame_wrap: got %s want x=0 y=0 ls=1 fs=1", fmt(obs_s));
                end
            end
            px = s_x; py = s_y;
        end
        checks++;
        if (!(hit_a && hit_b && hit_c && hit_w)) begin
            failures++;
            $display("FAIL edge_coverage: got hits %0b%0b%0b%0b want 1111",
                     hit_a, hit_b, hit_c, hit_w);
        end
    endtask

    task automatic test_async_reset();
        obs_t e;
        int   waited;
        restart();
        waited = 0;
        while (!(m_x === 10'd300 && m_y === 10'd1) && waited < 5000) begin
            step();
            waited++;
        end
        checks++;
        if (waited >= 5000) begin
            failures++;
            $display("FAIL midline_reach: got (%0d,%0d) want (300,1)", m_x, m_y);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_m !== RST_EXP) begin
            failures++;
            $display("FAIL async_reset_main: got %s want %s", fmt(obs_m), fmt(RST_EXP));
        end
        checks++;
        if (obs_s !== RST_EXP) begin
            failures++;
            $display("FAIL async_reset_small: got %s want %s", fmt(obs_s), fmt(RST_EXP));
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb_q.delete();
        for (int n = 0; n <= 40; n++) begin
            sb_q.push_back(model(n, G_DEF));
            sb_q.push_back(model(n, G_S));
            if (n > 0) step();
            e = sb_q.pop_front();
            checks++;
            if (obs_m !== e) begin
                failures++;
                $display("FAIL restart_main_n%0d: got %s want %s", n, fmt(obs_m), fmt(e));
            end
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                failures++;
                $display("FAIL restart_small_n%0d: got %s want %s", n, fmt(obs_s), fmt(e));
            end
        end
    endtask

    task automatic test_div1();
        obs_t e;
        int   ls_n[$];
        int   ce_zero;
        ce_zero = 0;
        restart();
        for (int n = 0; n <= 1700; n++) begin
            sb_q.push_back(model(n, G_1));
            if (n > 0) step();
            e = sb_q.pop_front();
            checks++;
            if (obs_o !== e) begin
                failures++;
                $display("FAIL div1_sb_n%0d: got %s want %s", n, fmt(obs_o), fmt(e));
            end
            if (o_ce !== 1'b1) ce_zero++;
            if (o_ls === 1'b1) ls_n.push_back(n);
        end
        checks++;
        if (ce_zero != 0) begin
            failures++;
            $display("FAIL div1_ce_const: got %0d low cycles want 0", ce_zero);
        end
        checks++;
        if (ls_n.size() < 2 || (ls_n[1] - ls_n[0]) != 800) begin
            failures++;
            $display("FAIL div1_line_period: got %0d pulses, gap %0d want gap 800", ls_n.size(),
                     (ls_n.size() >= 2) ? ls_n[1] - ls_n[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_edges();
        test_async_reset();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
